prbs_sync_checker: RTL



---
 rtl/prbs_pkg.sv | 55 +++++
 rtl/prbs_par_lfsr.sv | 38 +++
 rtl/prbs_sync_checker.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared constants for the parallel PRBS checker.
// poly_sel codes, per-polynomial length/tap tables, FSM state type.
package prbs_pkg;

  localparam int MAX_LEN = 31;

  localparam logic [2:0] SEL_PRBS7  = 3'd0;
  localparam logic [2:0] SEL_PRBS9  = 3'd1;
  localparam logic [2:0] SEL_PRBS15 = 3'd2;
  localparam logic [2:0] SEL_PRBS23 = 3'd3;
  localparam logic [2:0] SEL_PRBS31 = 3'd4;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } chk_state_e;

  // Codes 5..7 fall through to PRBS31.
  function automatic logic [4:0] poly_len(input logic [2:0] sel);
    logic [4:0] r;
    unique case (sel)
      SEL_PRBS7:  r = 5'd7;
      SEL_PRBS9:  r = 5'd9;
      SEL_PRBS15: r = 5'd15;
      SEL_PRBS23: r = 5'd23;
      default:    r = 5'd31;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] poly_tap_a(input logic [2:0] sel);
    logic [4:0] r;
    unique case (sel)
      SEL_PRBS7:  r = 5'd6;
      SEL_PRBS9:  r = 5'd8;
      SEL_PRBS15: r = 5'd14;
      SEL_PRBS23: r = 5'd22;
      default:    r = 5'd30;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] poly_tap_b(input logic [2:0] sel);
    logic [4:0] r;
    unique case (sel)
      SEL_PRBS7:  r = 5'd5;
      SEL_PRBS9:  r = 5'd4;
      SEL_PRBS15: r = 5'd13;
      SEL_PRBS23: r = 5'd17;
      default:    r = 5'd27;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/prbs_par_lfsr.sv
// prbs_par_lfsr: W-step unrolled Fibonacci PRBS predictor (combinational).
// Ports: poly_sel_i, sync_i (1: shift in received bits, 0: shift in
// predicted bits), state_i/state_o (31-bit history, bit 0 newest),
// bits_i (bit W-1 oldest), pred_o (predicted bit per position).
module prbs_par_lfsr
  import prbs_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]         poly_sel_i,
  input  logic               sync_i,
  input  logic [MAX_LEN-1:0] state_i,
  input  logic [W-1:0]       bits_i,
  output logic [W-1:0]       pred_o,
  output logic [MAX_LEN-1:0] state_o
);

  logic [4:0]         tap_a;
  logic [4:0]         tap_b;
  logic [MAX_LEN-1:0] s;
  logic               p;

  assign tap_a = poly_tap_a(poly_sel_i);
  assign tap_b = poly_tap_b(poly_sel_i);

  always_comb begin
    s      = state_i;
    p      = 1'b0;
    pred_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      p         = s[tap_a] ^ s[tap_b];
      pred_o[i] = p;
      s         = {s[MAX_LEN-2:0], sync_i ? bits_i[i] : p};
    end
    state_o = s;
  end

endmodule

// File: rtl/prbs_sync_checker.sv
// prbs_sync_checker: self-synchronising multi-polynomial PRBS checker.
// In: clk, rst (sync, active-high), poly_sel, data_in[W], data_in_valid,
// clear_cnt. Out: locked, total_bits, total_bit_errors, lock_losses,
// and err_mask/err_mask_valid when PRBS_CHK_ERR_MASK_EN is defined.
module prbs_sync_checker
  import prbs_pkg::*;
#(
  parameter int W          = 8,
  parameter int CNT_W      = 32,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       poly_sel,
  input  logic [W-1:0]     data_in,
  input  logic             data_in_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic [CNT_W-1:0] total_bits,
  output logic [CNT_W-1:0] total_bit_errors,
  output logic [15:0]      lock_losses
`ifdef PRBS_CHK_ERR_MASK_EN
  ,
  output logic [W-1:0]     err_mask,
  output logic             err_mask_valid
`endif
);

  localparam int          PC_W     = $clog2(W + 1);
  localparam logic [15:0] LOCK_N   = 16'(LOCK_CNT);
  localparam logic [15:0] UNLOCK_N = 16'(UNLOCK_CNT);

  chk_state_e         state_q;
  logic               locked_q;
  logic [2:0]         poly_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [MAX_LEN-1:0] hist_d;
  logic [MAX_LEN-1:0] lfsr_q;
  logic [MAX_LEN-1:0] lfsr_d;
  logic [4:0]         fill_q;
  logic [4:0]         fill_d;
  logic [15:0]        streak_q;
  logic [15:0]        run_q;
  logic [CNT_W-1:0]   bits_q;
  logic [CNT_W-1:0]   bits_d;
  logic [CNT_W-1:0]   errs_q;
  logic [CNT_W-1:0]   errs_d;
  logic [15:0]        losses_q;
  logic [15:0]        losses_d;

  logic [W-1:0]       pred_srch;
  logic [W-1:0]       pred_lock;
  logic [W-1:0]       mism_srch;
  logic [W-1:0]       mism_lock;
  logic [PC_W-1:0]    popcnt;
  logic [7:0]         fill_sum;
  logic [CNT_W:0]     bits_sum;
  logic [CNT_W:0]     errs_sum;
  logic               eligible;
  logic               poly_chg;
  logic               srch_clean;
  logic               lock_err;

  // Search path predicts from the received history itself.
  prbs_par_lfsr #(.W(W)) u_srch (
    .poly_sel_i (poly_q),
    .sync_i     (1'b1),
    .state_i    (hist_q),
    .bits_i     (data_in),
    .pred_o     (pred_srch),
    .state_o    (hist_d)
  );

  // Locked path free-runs, so one channel error counts once.
  prbs_par_lfsr #(.W(W)) u_lock (
    .poly_sel_i (poly_q),
    .sync_i     (1'b0),
    .state_i    (lfsr_q),
    .bits_i     (data_in),
    .pred_o     (pred_lock),
    .state_o    (lfsr_d)
  );

  assign mism_srch  = data_in ^ pred_srch;
  assign mism_lock  = data_in ^ pred_lock;
  assign srch_clean = (mism_srch == '0);
  assign lock_err   = |mism_lock;
  assign poly_chg   = (poly_sel != poly_q);
  assign eligible   = (fill_q >= poly_len(poly_q));

  assign fill_sum = 8'(fill_q) + 8'(W);
  assign fill_d   = (fill_sum >= 8'(MAX_LEN)) ? 5'(MAX_LEN)
                                              : fill_sum[4:0];

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < W; i++) begin
      popcnt = popcnt + PC_W'(mism_lock[i]);
    end
  end

  assign bits_sum = {1'b0, bits_q} + (CNT_W + 1)'(W);
  assign errs_sum = {1'b0, errs_q} + (CNT_W + 1)'(popcnt);
  assign bits_d   = bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
  assign errs_d   = errs_sum[CNT_W] ? '1 : errs_sum[CNT_W-1:0];
  assign losses_d = (&losses_q) ? losses_q : losses_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SEARCH;
      locked_q <= 1'b0;
      poly_q   <= poly_sel;
      hist_q   <= '0;
      lfsr_q   <= '0;
      fill_q   <= '0;
      streak_q <= '0;
      run_q    <= '0;
      bits_q   <= '0;
      errs_q   <= '0;
      losses_q <= '0;
    end else begin
      poly_q <= poly_sel;
      if (poly_chg) begin
        // Old history is meaningless under the new polynomial.
        state_q  <= ST_SEARCH;
        locked_q <= 1'b0;
        fill_q   <= '0;
        streak_q <= '0;
        run_q    <= '0;
      end else if (data_in_valid) begin
        hist_q <= hist_d;
        fill_q <= fill_d;
        unique case (state_q)
          ST_SEARCH: begin
            if (eligible) begin
              if (!srch_clean) begin
                streak_q <= '0;
              end else if (streak_q + 16'd1 == LOCK_N) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
                lfsr_q   <= hist_d;
                streak_q <= '0;
                run_q    <= '0;
              end else begin
                streak_q <= streak_q + 16'd1;
              end
            end
          end
          ST_LOCKED: begin
            lfsr_q <= lfsr_d;
            bits_q <= bits_d;
            errs_q <= errs_d;
            if (!lock_err) begin
              run_q <= '0;
            end else if (run_q + 16'd1 == UNLOCK_N) begin
              state_q  <= ST_SEARCH;
              locked_q <= 1'b0;
              fill_q   <= '0;
              streak_q <= '0;
              run_q    <= '0;
              losses_q <= losses_d;
            end else begin
              run_q <= run_q + 16'd1;
            end
          end
          default: ;
        endcase
      end
      // Clear overrides any same-cycle update.
      if (clear_cnt) begin
        bits_q   <= '0;
        errs_q   <= '0;
        losses_q <= '0;
      end
    end
  end

  assign locked           = locked_q;
  assign total_bits       = bits_q;
  assign total_bit_errors = errs_q;
  assign lock_losses      = losses_q;

`ifdef PRBS_CHK_ERR_MASK_EN
  logic [W-1:0] mask_q;
  logic         mask_v_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q   <= '0;
      mask_v_q <= 1'b0;
    end else begin
      mask_v_q <= 1'b0;
      if (!poly_chg && data_in_valid &&
          state_q == ST_LOCKED) begin
        mask_q   <= mism_lock;
        mask_v_q <= 1'b1;
      end
    end
  end

  assign err_mask       = mask_q;
  assign err_mask_valid = mask_v_q;
`else
  // Mask outputs compiled out; mismatches feed only the counters.
`endif

endmodule
